// File: rtl/alu4_pkg.sv
// alu4_pkg: op encoding, dispatcher FSM states and response flag layout shared by
// alu4_dispatch and its testbench.
package alu4_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_NOT = 3'd2,
        OP_AND = 3'd3,
        OP_OR  = 3'd4,
        OP_XOR = 3'd5,
        OP_SLT = 3'd6,
        OP_EQ  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_OVF   = 1;
    localparam int FLAG_CARRY = 2;
    localparam int FLAG_SIZE  = 3;

    // Compare ops only report through the response; they never retire to a register.
    function automatic logic writes_rf(input op_e op);
        return op != OP_SLT && op != OP_EQ;
    endfunction

endpackage

// File: rtl/alu4_regfile.sv
// alu4_regfile: REG_CNT x 4-bit register file, two async read ports, one sync write
// port, r0 hardwired to zero, async active-low clear.
module alu4_regfile #(
    parameter int REG_CNT = 8,
    localparam int AW = $clog2(REG_CNT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] addr_a,
    input  logic [AW-1:0] addr_b,
    output logic [3:0]    data_a,
    output logic [3:0]    data_b,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [3:0]    wr_data
);

    logic [3:0] mem [REG_CNT];

    assign data_a = (addr_a == '0) ? 4'd0 : mem[addr_a];
    assign data_b = (addr_b == '0) ? 4'd0 : mem[addr_b];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_CNT; i++) mem[i] <= '0;
        end else if (wr_en && wr_addr != '0) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/alu4_dispatch.sv
// alu4_dispatch: command dispatcher for an external 4-bit ALU (IDLE -> EXEC -> RESP).
// Define ALU4_DISPATCH_OVERLAP_EN to accept the next command while the response retires.
module alu4_dispatch
    import alu4_pkg::*;
#(
    parameter int REG_CNT = 8,
    localparam int AW = $clog2(REG_CNT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_rd,
    input  logic [AW-1:0] cmd_rs1,
    input  logic [AW-1:0] cmd_rs2,
    input  logic          cmd_cin,
    output logic [3:0]    alu_a,
    output logic [3:0]    alu_b,
    output logic [2:0]    alu_c,
    output logic          alu_cin,
    input  logic [3:0]    alu_result,
    input  logic          alu_zero,
    input  logic          alu_overflow,
    input  logic          alu_carry,
    input  logic          alu_size,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [3:0]    rsp_result,
    output logic [3:0]    rsp_flags,
    output logic [AW-1:0] rsp_rd
);

    state_e        state, state_n;
    op_e           op_q;
    logic          live;
    logic          accept;
    logic [AW-1:0] rd_q;
    logic [3:0]    rf_a, rf_b, flags;

    // live keeps cmd_ready low while in reset and for the edge that releases it.
`ifdef ALU4_DISPATCH_OVERLAP_EN
    assign cmd_ready = live && (state == ST_IDLE || (state == ST_RESP && rsp_ready));
`else
    assign cmd_ready = live && state == ST_IDLE;
`endif
    assign accept    = cmd_valid && cmd_ready;
    assign rsp_valid = state == ST_RESP;
    assign alu_c     = op_q;

    always_comb begin
        flags             = '0;
        flags[FLAG_ZERO]  = alu_zero;
        flags[FLAG_OVF]   = alu_overflow;
        flags[FLAG_CARRY] = alu_carry;
        flags[FLAG_SIZE]  = alu_size;
        state_n = (state == ST_EXEC)                ? ST_RESP :
                  accept                            ? ST_EXEC :
                  (state == ST_RESP && !rsp_ready)  ? ST_RESP : ST_IDLE;
    end

    alu4_regfile #(.REG_CNT(REG_CNT)) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .addr_a  (cmd_rs1),
        .addr_b  (cmd_rs2),
        .data_a  (rf_a),
        .data_b  (rf_b),
        .wr_en   (state == ST_EXEC && writes_rf(op_q)),
        .wr_addr (rd_q),
        .wr_data (alu_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            live       <= 1'b0;
            op_q       <= OP_ADD;
            rd_q       <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_cin    <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_rd     <= '0;
        end else begin
            state <= state_n;
            live  <= 1'b1;
            if (accept) begin
                op_q    <= op_e'(cmd_op);
                rd_q    <= cmd_rd;
                alu_a   <= rf_a;
                alu_b   <= rf_b;
                alu_cin <= cmd_cin;
            end
            if (state == ST_EXEC) begin
                rsp_result <= alu_result;
                rsp_flags  <= flags;
                rsp_rd     <= rd_q;
            end
        end
    end

endmodule

// File: tb/tb_alu4_dispatch.sv
// tb_alu4_dispatch: table-driven scoreboard bench for alu4_dispatch with a behavioural
// downstream ALU; honours ALU4_DISPATCH_OVERLAP_EN for the streaming throughput check.
module tb_alu4_dispatch;
    import alu4_pkg::*;

    typedef struct {
        logic [2:0] op;
        logic [2:0] rd;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic       cin;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] res;
        logic [3:0] flags;
        int         cyc;
    } vec_t;

`ifdef ALU4_DISPATCH_OVERLAP_EN
    localparam int STREAM_CYC = 8;
`else
    localparam int STREAM_CYC = 11;
`endif

    logic clk = 0, rst_n = 1, cmd_valid = 0, cmd_cin = 0, rsp_ready = 1;
    logic [2:0] cmd_op = 0, cmd_rd = 0, cmd_rs1 = 0, cmd_rs2 = 0;
    logic cmd_ready, alu_cin, alu_zero, alu_overflow, alu_carry, alu_size, rsp_valid;
    logic [2:0] alu_c, rsp_rd;
    logic [3:0] alu_a, alu_b, alu_result, rsp_result, rsp_flags;
    logic [4:0] s;

    int   tests = 0, fails = 0, cyc = 0, last_acc = 0, last_pop = 0, first_acc = 0;
    vec_t q[$];
    vec_t pend;
    bit   pend_v = 0, seen = 0;
    vec_t tbl[16];

    alu4_dispatch #(.REG_CNT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_cin(cmd_cin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_cin(alu_cin),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .alu_carry(alu_carry), .alu_size(alu_size),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_rd(rsp_rd)
    );

    always #5 clk = ~clk;

    // Downstream ALU: EQ reports equality through zero (result a^b), compares set size.
    always_comb begin
        s            = '0;
        alu_result   = '0;
        alu_carry    = 1'b0;
        alu_overflow = 1'b0;
        case (alu_c)
            3'd0: begin
                s            = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
                alu_result   = s[3:0];
                alu_carry    = s[4];
                alu_overflow = (alu_a[3] == alu_b[3]) && (s[3] != alu_a[3]);
            end
            3'd1: begin
                s            = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
                alu_result   = s[3:0];
                alu_carry    = s[4];
                alu_overflow = (alu_a[3] != alu_b[3]) && (s[3] != alu_a[3]);
            end
            3'd2: alu_result = ~alu_a;
            3'd3: alu_result = alu_a & alu_b;
            3'd4: alu_result = alu_a | alu_b;
            3'd5: alu_result = alu_a ^ alu_b;
            3'd6: alu_result = {3'b0, $signed(alu_a) < $signed(alu_b)};
            default: alu_result = alu_a ^ alu_b;
        endcase
        alu_zero = alu_result == 4'd0;
        alu_size = alu_c[2] & alu_c[1];
    end

    function automatic vec_t mk(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                                input logic [2:0] rs2, input logic cin, input logic [3:0] a,
                                input logic [3:0] b, input logic [3:0] res, input logic [3:0] flags);
        vec_t v;
        v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.cin = cin;
        v.a = a; v.b = b; v.res = res; v.flags = flags; v.cyc = 0;
        return v;
    endfunction

    task automatic chk(input string n, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", n, act, exp);
        end
    endtask

    task automatic send(input vec_t v);
        int n = 0;
        cmd_op = v.op; cmd_rd = v.rd; cmd_rs1 = v.rs1; cmd_rs2 = v.rs2; cmd_cin = v.cin;
        cmd_valid = 1;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 50);
        if (!cmd_ready) begin
            chk("accept_timeout", 0, 1);
            cmd_valid = 0;
        end else begin
            v.cyc = cyc;
            q.push_back(v);
            pend = v;
            pend_v = 1;
            last_acc = cyc;
            @(posedge clk);
            #1 cmd_valid = 0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Scoreboard monitor: responses against the queue head, operands one cycle after accept.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            q.delete();
            pend_v = 0;
            seen = 0;
        end else begin
            if (rsp_valid) begin
                if (q.size() == 0) chk("spurious_rsp", 1, 0);
                else begin
                    if (!seen) chk("latency", cyc - q[0].cyc, 2);
                    seen = 1;
                    chk("rsp_result", int'(rsp_result), int'(q[0].res));
                    chk("rsp_flags", int'(rsp_flags), int'(q[0].flags));
                    chk("rsp_rd", int'(rsp_rd), int'(q[0].rd));
                    if (!rsp_ready) chk("ready_in_stall", int'(cmd_ready), 0);
                    else begin
                        void'(q.pop_front());
                        seen = 0;
                        last_pop = cyc;
                    end
                end
            end
            if (pend_v && cyc == pend.cyc + 1) begin
                chk("exec_alu_a", int'(alu_a), int'(pend.a));
                chk("exec_alu_b", int'(alu_b), int'(pend.b));
                chk("exec_alu_c", int'(alu_c), int'(pend.op));
                chk("exec_alu_cin", int'(alu_cin), int'(pend.cin));
                chk("exec_rsp_valid", int'(rsp_valid), 0);
                pend_v = 0;
            end
        end
    end

    initial begin
        tbl[0]  = mk(OP_ADD, 1, 0, 0, 1, 0, 0, 1, 4'b0000);
        tbl[1]  = mk(OP_ADD, 1, 1, 1, 1, 1, 1, 3, 4'b0000);
        tbl[2]  = mk(OP_ADD, 2, 1, 0, 1, 3, 0, 4, 4'b0000);
        tbl[3]  = mk(OP_ADD, 2, 2, 0, 1, 4, 0, 5, 4'b0000);
        tbl[4]  = mk(OP_ADD, 3, 1, 2, 0, 3, 5, 8, 4'b0010);
        tbl[5]  = mk(OP_EQ,  3, 1, 1, 0, 3, 3, 0, 4'b1001);
        tbl[6]  = mk(OP_ADD, 0, 3, 0, 0, 8, 0, 8, 4'b0000);
        tbl[7]  = mk(OP_XOR, 0, 1, 2, 0, 3, 5, 6, 4'b0000);
        tbl[8]  = mk(OP_ADD, 5, 0, 0, 0, 0, 0, 0, 4'b0001);
        tbl[9]  = mk(OP_SUB, 6, 1, 2, 0, 3, 5, 14, 4'b0000);
        tbl[10] = mk(OP_NOT, 7, 2, 0, 0, 5, 0, 10, 4'b0000);
        tbl[11] = mk(OP_AND, 5, 6, 7, 0, 14, 10, 10, 4'b0000);
        tbl[12] = mk(OP_OR,  4, 1, 3, 0, 3, 8, 11, 4'b0000);
        tbl[13] = mk(OP_SLT, 2, 3, 1, 0, 8, 3, 1, 4'b1000);
        tbl[14] = mk(OP_ADD, 0, 2, 5, 0, 5, 10, 15, 4'b0000);
        tbl[15] = mk(OP_ADD, 0, 4, 0, 0, 11, 0, 11, 4'b0000);

        #2 rst_n = 0;
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", int'(cmd_ready), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_result", int'(rsp_result), 0);
        chk("rst_rsp_flags", int'(rsp_flags), 0);
        chk("rst_rsp_rd", int'(rsp_rd), 0);
        chk("rst_alu_a", int'(alu_a), 0);
        chk("rst_alu_b", int'(alu_b), 0);
        chk("rst_alu_c", int'(alu_c), 0);
        chk("rst_alu_cin", int'(alu_cin), 0);
        @(posedge clk);
        #1 rst_n = 1;

        foreach (tbl[i]) send(tbl[i]);
        drain();

        // Back-pressure: response must hold while rsp_ready is low.
        rsp_ready = 0;
        send(mk(OP_NOT, 0, 1, 0, 0, 3, 0, 12, 4'b0000));
        repeat (6) @(negedge clk);
        @(posedge clk);
        #1 rsp_ready = 1;
        @(negedge clk);
        @(negedge clk);
        chk("release_rsp_valid", int'(rsp_valid), 0);
        chk("release_cmd_ready", int'(cmd_ready), 1);
        @(posedge clk);
        #1;

        // Reset pulse while ADD rd=4 is executing.
        send(mk(OP_ADD, 4, 3, 1, 0, 8, 3, 11, 4'b0000));
        #2 rst_n = 0;
        @(negedge clk);
        chk("abort_rsp_valid", int'(rsp_valid), 0);
        chk("abort_cmd_ready", int'(cmd_ready), 0);
        chk("abort_alu_a", int'(alu_a), 0);
        chk("abort_alu_b", int'(alu_b), 0);
        chk("abort_alu_c", int'(alu_c), 0);
        chk("abort_rsp_result", int'(rsp_result), 0);
        chk("abort_rsp_flags", int'(rsp_flags), 0);
        @(negedge clk);
        chk("abort_no_rsp", int'(rsp_valid), 0);
        @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("ready_before_edge", int'(cmd_ready), 0);
        @(negedge clk);
        chk("ready_after_edge", int'(cmd_ready), 1);
        @(posedge clk);
        #1;
        send(mk(OP_ADD, 0, 4, 0, 0, 0, 0, 0, 4'b0001));
        send(mk(OP_ADD, 0, 3, 1, 0, 0, 0, 0, 4'b0001));
        drain();

        // Dependent stream with rsp_ready held high.
        send(mk(OP_ADD, 1, 0, 0, 1, 0, 0, 1, 4'b0000));
        first_acc = last_acc;
        send(mk(OP_ADD, 1, 1, 1, 1, 1, 1, 3, 4'b0000));
        send(mk(OP_ADD, 2, 1, 1, 0, 3, 3, 6, 4'b0000));
        send(mk(OP_SUB, 3, 1, 2, 0, 3, 6, 13, 4'b0000));
        drain();
        chk("stream_cycles", last_pop - first_acc, STREAM_CYC);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
